// File: rtl/dotmatrix_rx.sv
// Dot-matrix display snooper: synchronizes the row/column shift interface of a
// display driver and turns each lit row into a {row_idx, row_data} record.
module dotmatrix_rx #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        rclk,
   input  logic        rsdi,
   input  logic        oeb,
   input  logic        csdi,
   input  logic        cclk,
   input  logic        le,
   output logic        row_valid,
   input  logic        row_ready,
   output logic [4:0]  row_idx,
   output logic [31:0] row_data,
   output logic [7:0]  frame_count,
   output logic        err_onehot,
   output logic        overflow
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ARMED = 2'd1,
      S_EMIT  = 2'd2
   } state_t;

   // Synchronizer bit order: {le, csdi, cclk, oeb, rsdi, rclk}; oeb idles high.
   localparam logic [5:0] SYNC_INIT = 6'b000100;
   localparam logic [3:0] PREV_INIT = 4'b0010;

   logic [5:0]  sync_q [SYNC_STAGES];
   logic [5:0]  sync_w;
   logic [3:0]  prev_q;
   logic        rclk_rise, oeb_fall, cclk_rise, le_rise;

   logic [31:0] col_sr_q, col_sr_d;
   logic [31:0] col_lat_q, col_lat_d;
   logic [31:0] row_sr_q, row_sr_d;

   state_t      state_q, state_d;
   logic        push, err_set, row_onehot, xfer;
   logic [4:0]  row_pos;

   logic        valid_q, valid_d;
   logic [4:0]  idx_q, idx_d;
   logic [31:0] data_q, data_d;
   logic [7:0]  frame_q, frame_d;
   logic        err_q, err_d;
   logic        ovf_q, ovf_d;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_INIT;
         prev_q <= PREV_INIT;
      end else begin
         sync_q[0] <= {le, csdi, cclk, oeb, rsdi, rclk};
         for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
         prev_q <= {sync_w[5], sync_w[3], sync_w[2], sync_w[0]};
      end
   end

   assign sync_w    = sync_q[SYNC_STAGES-1];
   assign rclk_rise =  sync_w[0] & ~prev_q[0];
   assign oeb_fall  = ~sync_w[2] &  prev_q[1];
   assign cclk_rise =  sync_w[3] & ~prev_q[2];
   assign le_rise   =  sync_w[5] & ~prev_q[3];

   // Latch takes the shifted value so a coincident cclk/le edge captures the new bit.
   always_comb begin
      col_sr_d  = col_sr_q;
      col_lat_d = col_lat_q;
      row_sr_d  = row_sr_q;
      if (cclk_rise) col_sr_d = {col_sr_q[30:0], sync_w[4]};
      if (le_rise)   col_lat_d = col_sr_d;
      if (rclk_rise) row_sr_d = {row_sr_q[30:0], sync_w[1]};
   end

   assign row_onehot = (row_sr_q != '0) && ((row_sr_q & (row_sr_q - 32'd1)) == '0);

   always_comb begin
      row_pos = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         if (row_sr_q[i]) row_pos = 5'(i);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      push    = 1'b0;
      err_set = 1'b0;
      unique case (state_q)
         S_IDLE:  if (le_rise)  state_d = S_ARMED;
         S_ARMED: if (oeb_fall) state_d = S_EMIT;
         S_EMIT: begin
            state_d = S_IDLE;
            if (row_onehot) push    = 1'b1;
            else            err_set = 1'b1;
         end
         default: state_d = S_IDLE;
      endcase
   end

   assign xfer = valid_q & row_ready;

   always_comb begin
      valid_d = valid_q;
      idx_d   = idx_q;
      data_d  = data_q;
      frame_d = frame_q;
      ovf_d   = ovf_q;
      err_d   = err_q | err_set;
      if (push && (!valid_q || xfer)) begin
         valid_d = 1'b1;
         idx_d   = row_pos;
         data_d  = col_lat_q;
         if (row_pos == 5'd31) frame_d = frame_q + 8'd1;
      end else if (push) begin
         ovf_d = 1'b1;
      end else if (xfer) begin
         valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         col_sr_q  <= '0;
         col_lat_q <= '0;
         row_sr_q  <= '0;
         valid_q   <= 1'b0;
         idx_q     <= '0;
         data_q    <= '0;
         frame_q   <= '0;
         err_q     <= 1'b0;
         ovf_q     <= 1'b0;
      end else begin
         col_sr_q  <= col_sr_d;
         col_lat_q <= col_lat_d;
         row_sr_q  <= row_sr_d;
         valid_q   <= valid_d;
         idx_q     <= idx_d;
         data_q    <= data_d;
         frame_q   <= frame_d;
         err_q     <= err_d;
         ovf_q     <= ovf_d;
      end
   end

   assign row_valid   = valid_q;
   assign row_idx     = idx_q;
   assign row_data    = data_q;
   assign frame_count = frame_q;
   assign err_onehot  = err_q;
   assign overflow    = ovf_q;

endmodule

// File: tb/tb_dotmatrix_rx.sv
// Directed bench for dotmatrix_rx with hand-computed expectations (SYNC_STAGES = 2).
module tb_dotmatrix_rx;

   logic        clk = 1'b0;
   logic        reset;
   logic        rclk = 1'b0, rsdi = 1'b0, oeb = 1'b1;
   logic        csdi = 1'b0, cclk = 1'b0, le = 1'b0;
   logic        row_valid, row_ready = 1'b0;
   logic [4:0]  row_idx;
   logic [31:0] row_data;
   logic [7:0]  frame_count;
   logic        err_onehot, overflow;

   int n_cmp = 0;
   int n_err = 0;

   dotmatrix_rx #(.SYNC_STAGES(2)) dut (
      .clk(clk), .reset(reset), .rclk(rclk), .rsdi(rsdi), .oeb(oeb),
      .csdi(csdi), .cclk(cclk), .le(le), .row_valid(row_valid),
      .row_ready(row_ready), .row_idx(row_idx), .row_data(row_data),
      .frame_count(frame_count), .err_onehot(err_onehot), .overflow(overflow)
   );

   always #5 clk = ~clk;

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic shift_col(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) begin
         csdi = w[i]; wait_cyc(2);
         cclk = 1'b1; wait_cyc(2);
         cclk = 1'b0;
      end
      wait_cyc(2);
   endtask

   task automatic shift_row(input logic [31:0] w);
      for (int i = 31; i >= 0; i--) begin
         rsdi = w[i]; wait_cyc(2);
         rclk = 1'b1; wait_cyc(2);
         rclk = 1'b0;
      end
      wait_cyc(2);
   endtask

   task automatic pulse_le();
      le = 1'b1; wait_cyc(3);
      le = 1'b0; wait_cyc(3);
   endtask

   task automatic pulse_oeb();
      oeb = 1'b0; wait_cyc(8);
      oeb = 1'b1; wait_cyc(3);
   endtask

   task automatic send_row(input logic [31:0] col, input logic [31:0] row);
      shift_col(col);
      pulse_le();
      shift_row(row);
      pulse_oeb();
   endtask

   task automatic accept_one();
      row_ready = 1'b1; wait_cyc(1);
      row_ready = 1'b0;
   endtask

   task automatic test_reset();
      reset = 1'b1;
      #1 reset = 1'b0;
      wait_cyc(3);
      n_cmp++; if (row_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", row_valid); end
      n_cmp++; if (row_idx !== 5'd0) begin n_err++; $display("FAIL rst_idx: got %0d expected 0", row_idx); end
      n_cmp++; if (row_data !== 32'd0) begin n_err++; $display("FAIL rst_data: got %h expected 0", row_data); end
      n_cmp++; if (frame_count !== 8'd0) begin n_err++; $display("FAIL rst_frame: got %0d expected 0", frame_count); end
      n_cmp++; if (err_onehot !== 1'b0) begin n_err++; $display("FAIL rst_err: got %b expected 0", err_onehot); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b expected 0", overflow); end
      reset = 1'b1;
      wait_cyc(4);
      n_cmp++; if (row_valid !== 1'b0) begin n_err++; $display("FAIL rst_release_valid: got %b expected 0", row_valid); end
   endtask

   task automatic test_basic();
      int cyc;
      bit seen;
      shift_col(32'hA5A5_0F0F);
      pulse_le();
      shift_row(32'h0000_0008);
      oeb = 1'b0;
      seen = 1'b0;
      cyc = 0;
      for (int c = 1; c <= 20 && !seen; c++) begin
         @(negedge clk);
         if (row_valid === 1'b1) begin seen = 1'b1; cyc = c; end
      end
      n_cmp++; if (!seen || cyc > 6) begin n_err++; $display("FAIL basic_latency: got seen=%b cycles=%0d expected <=6", seen, cyc); end
      n_cmp++; if (row_idx !== 5'd3) begin n_err++; $display("FAIL basic_idx: got %0d expected 3", row_idx); end
      n_cmp++; if (row_data !== 32'hA5A5_0F0F) begin n_err++; $display("FAIL basic_data: got %h expected a5a50f0f", row_data); end
      oeb = 1'b1;
      wait_cyc(6);
      n_cmp++; if (row_valid !== 1'b1 || row_idx !== 5'd3 || row_data !== 32'hA5A5_0F0F)
         begin n_err++; $display("FAIL basic_hold: got v=%b idx=%0d data=%h expected v=1 idx=3 data=a5a50f0f", row_valid, row_idx, row_data); end
      accept_one();
      n_cmp++; if (row_valid !== 1'b0) begin n_err++; $display("FAIL basic_xfer: got %b expected 0", row_valid); end
      n_cmp++; if (frame_count !== 8'd0) begin n_err++; $display("FAIL basic_frame: got %0d expected 0", frame_count); end
   endtask

   task automatic test_onehot_err();
      shift_col(32'h1111_2222);
      pulse_le();
      shift_row(32'h0000_0006);
      pulse_oeb();
      wait_cyc(2);
      n_cmp++; if (err_onehot !== 1'b1) begin n_err++; $display("FAIL err_flag: got %b expected 1", err_onehot); end
      n_cmp++; if (row_valid !== 1'b0) begin n_err++; $display("FAIL err_valid: got %b expected 0", row_valid); end
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL err_ovf: got %b expected 0", overflow); end
   endtask

   task automatic test_idle_oeb();
      shift_row(32'h0000_0020);
      pulse_oeb();
      wait_cyc(2);
      n_cmp++; if (row_valid !== 1'b0) begin n_err++; $display("FAIL idle_no_record: got %b expected 0", row_valid); end
   endtask

   task automatic test_back_to_back();
      send_row(32'h0000_00AA, 32'h0000_0004);
      n_cmp++; if (row_valid !== 1'b1 || row_idx !== 5'd2) begin n_err++; $display("FAIL b2b_first: got v=%b idx=%0d expected v=1 idx=2", row_valid, row_idx); end
      shift_col(32'h5555_CCCC);
      pulse_le();
      shift_row(32'h0000_0010);
      oeb = 1'b0;
      wait_cyc(3);
      row_ready = 1'b1;
      wait_cyc(1);
      row_ready = 1'b0;
      n_cmp++; if (row_valid !== 1'b1) begin n_err++; $display("FAIL b2b_valid: got %b expected 1", row_valid); end
      n_cmp++; if (row_idx !== 5'd4) begin n_err++; $display("FAIL b2b_idx: got %0d expected 4", row_idx); end
      n_cmp++; if (row_data !== 32'h5555_CCCC) begin n_err++; $display("FAIL b2b_data: got %h expected 5555cccc", row_data); end
      oeb = 1'b1;
      wait_cyc(4);
      n_cmp++; if (overflow !== 1'b0) begin n_err++; $display("FAIL b2b_ovf: got %b expected 0", overflow); end
      accept_one();
      n_cmp++; if (row_valid !== 1'b0) begin n_err++; $display("FAIL b2b_drain: got %b expected 0", row_valid); end
   endtask

   task automatic test_overflow();
      send_row(32'h1234_5678, 32'h0000_0080);
      send_row(32'hDEAD_BEEF, 32'h0000_0200);
      n_cmp++; if (overflow !== 1'b1) begin n_err++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
      n_cmp++; if (row_valid !== 1'b1 || row_idx !== 5'd7) begin n_err++; $display("FAIL ovf_idx: got v=%b idx=%0d expected v=1 idx=7", row_valid, row_idx); end
      n_cmp++; if (row_data !== 32'h1234_5678) begin n_err++; $display("FAIL ovf_data: got %h expected 12345678", row_data); end
      accept_one();
      n_cmp++; if (row_valid !== 1'b0) begin n_err++; $display("FAIL ovf_drain: got %b expected 0", row_valid); end
   endtask

   task automatic test_frame_wrap();
      row_ready = 1'b1;
      shift_col(32'h8000_0001);
      shift_row(32'h8000_0000);
      for (int r = 0; r < 255; r++) begin
         pulse_le();
         pulse_oeb();
      end
      n_cmp++; if (frame_count !== 8'd255) begin n_err++; $display("FAIL frame_255: got %0d expected 255", frame_count); end
      pulse_le();
      pulse_oeb();
      n_cmp++; if (frame_count !== 8'd0) begin n_err++; $display("FAIL frame_wrap: got %0d expected 0", frame_count); end
      n_cmp++; if (err_onehot !== 1'b1 || overflow !== 1'b1) begin n_err++; $display("FAIL sticky: got err=%b ovf=%b expected 1 1", err_onehot, overflow); end
      row_ready = 1'b0;
      wait_cyc(1);
   endtask

   task automatic test_reset_midshift();
      pulse_le();
      pulse_oeb();
      n_cmp++; if (row_valid !== 1'b1 || frame_count !== 8'd1) begin n_err++; $display("FAIL mid_pre: got v=%b frame=%0d expected v=1 frame=1", row_valid, frame_count); end
      for (int i = 0; i < 10; i++) begin
         rsdi = 1'b1; wait_cyc(2);
         rclk = 1'b1; wait_cyc(2);
         rclk = 1'b0;
      end
      rclk = 1'b1;
      #2 reset = 1'b0;
      #1;
      n_cmp++; if (row_valid !== 1'b0 || row_idx !== 5'd0 || row_data !== 32'd0)
         begin n_err++; $display("FAIL mid_rst_rec: got v=%b idx=%0d data=%h expected 0 0 0", row_valid, row_idx, row_data); end
      n_cmp++; if (frame_count !== 8'd0 || err_onehot !== 1'b0 || overflow !== 1'b0)
         begin n_err++; $display("FAIL mid_rst_flags: got frame=%0d err=%b ovf=%b expected 0 0 0", frame_count, err_onehot, overflow); end
      rclk = 1'b0;
      rsdi = 1'b0;
      wait_cyc(3);
      reset = 1'b1;
      wait_cyc(3);
      send_row(32'h0F0F_00FF, 32'h0002_0000);
      n_cmp++; if (row_valid !== 1'b1 || row_idx !== 5'd17) begin n_err++; $display("FAIL mid_after_idx: got v=%b idx=%0d expected v=1 idx=17", row_valid, row_idx); end
      n_cmp++; if (row_data !== 32'h0F0F_00FF) begin n_err++; $display("FAIL mid_after_data: got %h expected 0f0f00ff", row_data); end
      n_cmp++; if (err_onehot !== 1'b0 || overflow !== 1'b0 || frame_count !== 8'd0)
         begin n_err++; $display("FAIL mid_after_flags: got err=%b ovf=%b frame=%0d expected 0 0 0", err_onehot, overflow, frame_count); end
   endtask

   initial begin
      test_reset();
      test_basic();
      test_onehot_err();
      test_idle_oeb();
      test_back_to_back();
      test_overflow();
      test_frame_wrap();
      test_reset_midshift();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/dotmatrix_rx.md
DOTMATRIX_RX -- requirements
Module: dotmatrix_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of synchronizer flops on each display input, legal range 2..4.
REQ-002 SHALL have port clk, input, 1 bit: the single system clock; every flop is clocked on its rising edge.
REQ-003 SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port rclk, input, 1 bit: row shift clock from the display driver, asynchronous to clk.
REQ-005 SHALL have port rsdi, input, 1 bit: row serial data, sampled on rising rclk.
REQ-006 SHALL have port oeb, input, 1 bit: output enable; low means the display is lit.
REQ-007 SHALL have port csdi, input, 1 bit: column serial data, sampled on rising cclk.
REQ-008 SHALL have port cclk, input, 1 bit: column shift clock, asynchronous to clk.
REQ-009 SHALL have port le, input, 1 bit: column latch enable; its rising edge latches the column data.
REQ-010 SHALL have port row_valid, output, 1 bit: a captured row record is available.
REQ-011 SHALL have port row_ready, input, 1 bit: the consumer accepts the current record.
REQ-012 SHALL have port row_idx, output, 5 bits: index of the lit row, 0..31.
REQ-013 SHALL have port row_data, output, 32 bits: column pattern for that row; bit n is column n.
REQ-014 SHALL have port frame_count, output, 8 bits: number of frames completed.
REQ-015 SHALL have port err_onehot, output, 1 bit: sticky flag, set when the row register is not one-hot.
REQ-016 SHALL have port overflow, output, 1 bit: sticky flag, set when a record is dropped.

Function
REQ-017 SHALL pass rclk, rsdi, oeb, cclk, csdi and le through SYNC_STAGES flops each, then detect edges on the synchronized versions.
REQ-018 SHALL, on each synchronized cclk rising edge, shift the synchronized csdi into bit 0 of a 32-bit column shift register, moving existing bits toward bit 31.
REQ-019 SHALL, on each synchronized le rising edge, copy the column shift register into a 32-bit column latch.
REQ-020 SHALL, on each synchronized rclk rising edge, shift the synchronized rsdi into bit 0 of a 32-bit row shift register.
REQ-021 SHALL, on the cycle after a synchronized oeb falling edge, form a record: row_data = column latch; row_idx = position of the single set bit in the row shift register.
REQ-022 SHALL implement a 3-state FSM:
- IDLE -> ARMED on an le rising edge.
- ARMED -> EMIT on an oeb falling edge.
- EMIT -> IDLE after one cycle, which pushes the record.
- An oeb falling edge seen in IDLE (no le since the last emit) produces no record.
REQ-023 SHALL, when the row shift register is zero or has more than one set bit at record formation, set err_onehot, push no record and return to IDLE.
REQ-024 SHALL hold the record in a 1-entry output buffer:
- row_valid rises one cycle after the EMIT push.
- row_idx and row_data stay stable while row_valid=1 and row_ready=0.
- Transfer occurs when row_valid=1 and row_ready=1.
REQ-025 SHALL accept the new record with no loss when a push and a transfer occur in the same cycle, so row_valid stays 1.
REQ-026 SHALL, when a push occurs while the buffer is full and not transferring, drop the new record, keep the old one and set overflow.
REQ-027 SHALL increment frame_count, wrapping 255 -> 0, when an accepted record has row_idx=31.
REQ-028 SHALL, when cclk and le edges are detected in the same cycle, apply the shift first so the latch captures the post-shift value.
REQ-029 SHALL clear err_onehot and overflow only by reset.

Reset
REQ-030 SHALL, while reset=0, asynchronously clear all synchronizers, shift registers, the latch, the FSM (to IDLE), the buffer, frame_count, err_onehot and overflow.
REQ-031 SHALL drive row_valid=0, row_idx=0, row_data=0, frame_count=0, err_onehot=0 and overflow=0 during reset.
REQ-032 SHALL initialize the synchronizer flops for oeb and le to 1 and 0 respectively, so no spurious edge fires after reset release.
REQ-033 SHALL discard any partially received row when reset is asserted mid-shift.

Verification
REQ-034 SHALL pass this check: shift 32 column bits encoding 0xA5A5_0F0F, pulse le, shift row one-hot bit 3, drop oeb -> row_valid=1 with row_idx=3 and row_data=0xA5A50F0F, within SYNC_STAGES+4 clk cycles.
REQ-035 SHALL pass this check: row register 0x0000_0006 at oeb fall -> err_onehot=1 and row_valid stays 0.
REQ-036 SHALL pass this check: two complete rows with row_ready=0 -> first record held, overflow=1; then row_ready=1 -> first record transferred and row_valid=0.
REQ-037 SHALL pass this check: push and transfer in the same cycle -> row_valid stays 1, new record presented, overflow=0.
REQ-038 SHALL pass this check: 256 records with row_idx=31 -> frame_count wraps to 0.
REQ-039 SHALL pass this check: reset=0 asserted mid-shift -> all outputs 0 immediately; the next full row after release is decoded correctly.
